// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared types and constants for the ALU arbiter slice.
//   - state_t      : sequencer states (IDLE, EXEC, RESP)
//   - REQ0 / REQ1  : requester ID encodings carried on resp_id
//   - ALU_SEL_*    : select codes understood by the companion alu model
//   - DEF_*        : default operand / select widths
// -----------------------------------------------------------------------------
package alu_arb_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Select codes of the shared alu. The arbiter itself never decodes these.
    localparam logic [3:0] ALU_SEL_ADD  = 4'h0;
    localparam logic [3:0] ALU_SEL_SUB  = 4'h1;
    localparam logic [3:0] ALU_SEL_AND  = 4'h2;
    localparam logic [3:0] ALU_SEL_OR   = 4'h3;
    localparam logic [3:0] ALU_SEL_XOR  = 4'h4;
    localparam logic [3:0] ALU_SEL_NOTA = 4'h5;
    localparam logic [3:0] ALU_SEL_SHL  = 4'h6;
    localparam logic [3:0] ALU_SEL_SHR  = 4'h7;
    localparam logic [3:0] ALU_SEL_INC  = 4'h8;
    localparam logic [3:0] ALU_SEL_DEC  = 4'h9;
    localparam logic [3:0] ALU_SEL_NAND = 4'hA;
    localparam logic [3:0] ALU_SEL_NOR  = 4'hB;
    localparam logic [3:0] ALU_SEL_XNOR = 4'hC;
    localparam logic [3:0] ALU_SEL_PA   = 4'hD;
    localparam logic [3:0] ALU_SEL_PB   = 4'hE;
    localparam logic [3:0] ALU_SEL_ADD1 = 4'hF;

    // Requester ID of a one-hot 2-bit grant vector.
    function automatic logic gnt_to_id(input logic [1:0] gnt);
        return gnt[1] ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational shared ALU that sits beside alu_arbiter.
// Ports:
//   i_a, i_b  in  WIDTH  operands
//   i_sel     in  SEL_W  operation select
//   o_out     out WIDTH  result
//   o_carry   out 1      carry-out (borrow for subtract/decrement,
//                        shifted-out bit for shifts, 0 for logic ops)
// -----------------------------------------------------------------------------
module alu
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [SEL_W-1:0] i_sel,
    output logic [WIDTH-1:0] o_out,
    output logic             o_carry
);

    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    // Result is computed one bit wider; the top bit is the carry-out.
    logic [WIDTH:0] w_res;
    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_b_ext;

    assign w_a_ext = {1'b0, i_a};
    assign w_b_ext = {1'b0, i_b};

    // NOTE: every signal driven in always_comb gets a default first, so no
    //       path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_res = '0;
        case (i_sel)
            ALU_SEL_ADD:  w_res = w_a_ext + w_b_ext;
            ALU_SEL_SUB:  w_res = w_a_ext - w_b_ext;
            ALU_SEL_AND:  w_res = {1'b0, i_a & i_b};
            ALU_SEL_OR:   w_res = {1'b0, i_a | i_b};
            ALU_SEL_XOR:  w_res = {1'b0, i_a ^ i_b};
            ALU_SEL_NOTA: w_res = {1'b0, ~i_a};
            ALU_SEL_SHL:  w_res = {i_a, 1'b0};
            ALU_SEL_SHR:  w_res = {i_a[0], 1'b0, i_a[WIDTH-1:1]};
            ALU_SEL_INC:  w_res = w_a_ext + ONE;
            ALU_SEL_DEC:  w_res = w_a_ext - ONE;
            ALU_SEL_NAND: w_res = {1'b0, ~(i_a & i_b)};
            ALU_SEL_NOR:  w_res = {1'b0, ~(i_a | i_b)};
            ALU_SEL_XNOR: w_res = {1'b0, ~(i_a ^ i_b)};
            ALU_SEL_PA:   w_res = w_a_ext;
            ALU_SEL_PB:   w_res = w_b_ext;
            ALU_SEL_ADD1: w_res = w_a_ext + w_b_ext + ONE;
            default:      w_res = '0;
        endcase
    end

    assign o_out   = w_res[WIDTH-1:0];
    assign o_carry = w_res[WIDTH];

endmodule

// File: rtl/alu_rr_arb2.sv
// -----------------------------------------------------------------------------
// alu_rr_arb2
// Two-way round-robin arbiter. Grants are combinational and only issued while
// enable is high; the last-grant pointer advances only when a grant is given.
// Ports:
//   clk     in  1  clock
//   rst     in  1  synchronous active-high reset (pointer favours requester 0)
//   req     in  2  request vector, bit i = requester i
//   enable  in  1  arbitration window open
//   gnt     out 2  one-hot grant (all zero when disabled or no request)
// -----------------------------------------------------------------------------
module alu_rr_arb2
    import alu_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    // Requester granted most recently. Resetting it to REQ1 makes REQ0 win
    // the first tie after reset.
    logic r_last;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (r_last == REQ1) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    //       registers update together on the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= REQ1;
        end else if (|gnt) begin
            r_last <= gnt_to_id(gnt);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational alu between two requesters. An accepted operation
// is registered onto the ALU inputs, the ALU result is captured one cycle
// later, and the result is returned with the issuing requester's ID on a
// backpressured response port. Only one operation is in flight at a time.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   req_valid / req_ready per-requester handshake (req_ready one-hot or zero)
//   req{0,1}_a/_b/_sel    per-requester operands and select
//   alu_a/alu_b/alu_sel   registered operands driven to the shared alu
//   alu_out/alu_carry     combinational alu result
//   resp_valid/resp_ready response handshake
//   resp_id/data/carry    requester ID, captured result and carry
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_carry
);

    state_t           r_state;
    state_t           w_next_state;

    logic [1:0]       w_gnt;
    logic             w_arb_en;
    logic             w_accept;
    logic             w_gnt_id;

    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [SEL_W-1:0] w_sel_sel;

    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [SEL_W-1:0] r_alu_sel;
    logic             r_resp_id;
    logic [WIDTH-1:0] r_resp_data;
    logic             r_resp_carry;

    // Grants are only offered in IDLE and never while reset is asserted, so
    // req_ready is zero in EXEC/RESP and during reset.
    assign w_arb_en = (r_state == IDLE) && !rst;

    alu_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .enable (w_arb_en),
        .gnt    (w_gnt)
    );

    assign req_ready = w_gnt;
    assign w_accept  = |w_gnt;
    assign w_gnt_id  = gnt_to_id(w_gnt);

    // Operand steering from the granted requester.
    assign w_sel_a   = (w_gnt_id == REQ1) ? req1_a   : req0_a;
    assign w_sel_b   = (w_gnt_id == REQ1) ? req1_b   : req0_b;
    assign w_sel_sel = (w_gnt_id == REQ1) ? req1_sel : req0_sel;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        resp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                // Masked during reset so an in-flight op can never complete
                // a handshake on the reset edge.
                resp_valid = !rst;
                if (resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------- operand / response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_resp_id    <= REQ0;
            r_resp_data  <= '0;
            r_resp_carry <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_accept) begin
                r_alu_a   <= w_sel_a;
                r_alu_b   <= w_sel_b;
                r_alu_sel <= w_sel_sel;
                r_resp_id <= w_gnt_id;
            end
            // ALU inputs have been stable for the whole EXEC cycle.
            if (r_state == EXEC) begin
                r_resp_data  <= alu_out;
                r_resp_carry <= alu_carry;
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign resp_carry = r_resp_carry;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter with the real alu on the alu_* ports.
// Expected responses are pushed to a scoreboard queue at each accept and
// popped when the DUT presents a response.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       carry;
    } resp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_sel, req1_sel;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_sel;
    logic       alu_carry;
    logic       resp_valid, resp_ready, resp_id, resp_carry;
    logic [7:0] resp_data;

    int    checks = 0;
    int    errors = 0;
    resp_t exp_q[$];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(8), .SEL_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .resp_carry(resp_carry)
    );

    alu #(.WIDTH(8), .SEL_W(4)) u_alu (
        .i_a(alu_a), .i_b(alu_b), .i_sel(alu_sel),
        .o_out(alu_out), .o_carry(alu_carry)
    );

    // Reference behaviour of the shared alu: {carry, data}.
    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] sel);
        int unsigned s;
        logic [8:0]  t;
        t = 9'h000;
        case (sel)
            4'd0:  begin s = a + b;     t = s[8:0]; end
            4'd1:  begin t[7:0] = a - b; t[8] = (a < b); end
            4'd2:  t[7:0] = a & b;
            4'd3:  t[7:0] = a | b;
            4'd4:  t[7:0] = a ^ b;
            4'd5:  t[7:0] = ~a;
            4'd6:  begin t[7:0] = a << 1; t[8] = a[7]; end
            4'd7:  begin t[7:0] = a >> 1; t[8] = a[0]; end
            4'd8:  begin s = a + 1;     t = s[8:0]; end
            4'd9:  begin t[7:0] = a - 8'd1; t[8] = (a == 8'd0); end
            4'd10: t[7:0] = ~(a & b);
            4'd11: t[7:0] = ~(a | b);
            4'd12: t[7:0] = ~(a ^ b);
            4'd13: t[7:0] = a;
            4'd14: t[7:0] = b;
            default: begin s = a + b + 1; t = s[8:0]; end
        endcase
        return t;
    endfunction

    function automatic resp_t make_exp(input logic id, input logic [7:0] a,
                                       input logic [7:0] b, input logic [3:0] sel);
        logic [8:0] m;
        m = alu_model(a, b, sel);
        return {id, m[7:0], m[8]};
    endfunction

    // Contention stimulus: op k of requester r.
    function automatic logic [7:0] op_a(input int r, input int k);
        return 8'hC0 + 8'(k * 32) + 8'(r);
    endfunction
    function automatic logic [7:0] op_b(input int r);
        return 8'h25 + 8'(r * 48);
    endfunction

    task automatic wait_ready(input int id, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            if (req_ready[id]) ok = 1'b1;
            else begin
                @(negedge clk); #1;
                n++;
            end
        end
    endtask

    task automatic wait_resp(output bit ok, output resp_t r, output int n);
        ok = 1'b0;
        n  = 0;
        r  = '0;
        while (!ok && n < 20) begin
            if (resp_valid) begin
                ok = 1'b1;
                r  = {resp_id, resp_data, resp_carry};
            end else begin
                @(negedge clk); #1;
                n++;
            end
        end
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset;
        bit    ok;
        int    n;
        resp_t r, e;
        rst = 1'b1;
        req0_a = 8'h11; req0_b = 8'h22; req0_sel = 4'h0;
        req1_a = 8'h33; req1_b = 8'h44; req1_sel = 4'h1;
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL rst_ready got %b exp 00", req_ready);
        end
        checks++;
        if ({alu_a, alu_b, alu_sel} !== 20'h0) begin
            errors++; $display("FAIL rst_alu got %h/%h/%h exp 0/0/0", alu_a, alu_b, alu_sel);
        end
        checks++;
        if ({resp_valid, resp_id, resp_data, resp_carry} !== 11'h0) begin
            errors++;
            $display("FAIL rst_resp got v%b id%b d%h c%b exp all 0",
                     resp_valid, resp_id, resp_data, resp_carry);
        end
        // Both valid at reset release: 0 first, then 1.
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL rel_first got %b exp 01", req_ready);
        end
        exp_q.push_back(make_exp(REQ0, req0_a, req0_b, req0_sel));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL exec_ready got %b exp 00", req_ready);
        end
        wait_resp(ok, r, n);
        e = exp_q.pop_front();
        checks++;
        if (!ok || r !== e) begin
            errors++; $display("FAIL rel_resp0 got ok%b %h exp %h", ok, r, e);
        end
        wait_ready(1, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rel_second got no grant exp req_ready[1]");
        end
        exp_q.push_back(make_exp(REQ1, req1_a, req1_b, req1_sel));
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_resp(ok, r, n);
        e = exp_q.pop_front();
        checks++;
        if (!ok || r !== e) begin
            errors++; $display("FAIL rel_resp1 got ok%b %h exp %h", ok, r, e);
        end
    endtask

    task automatic test_single;
        bit    ok;
        int    n;
        resp_t r, e;
        @(negedge clk);
        req0_a = 8'h0A; req0_b = 8'h02; req0_sel = ALU_SEL_ADD;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL single_ready got %b exp 01", req_ready);
        end
        exp_q.push_back({REQ0, 8'h0C, 1'b0});
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++;
        if ({alu_a, alu_b, alu_sel} !== {8'h0A, 8'h02, 4'h0}) begin
            errors++; $display("FAIL single_alu got %h/%h/%h exp 0a/02/0", alu_a, alu_b, alu_sel);
        end
        wait_resp(ok, r, n);
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL single_latency got %0d exp 2", n);
        end
        e = exp_q.pop_front();
        checks++;
        if (!ok || r !== e) begin
            errors++; $display("FAIL single_resp got ok%b %h exp %h", ok, r, e);
        end
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL single_done got %b exp 0", resp_valid);
        end
    endtask

    task automatic test_carry;
        bit    ok;
        int    n;
        resp_t r, e;
        @(negedge clk);
        req1_a = 8'hF6; req1_b = 8'h0A; req1_sel = ALU_SEL_ADD;
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL carry_ready got %b exp 10", req_ready);
        end
        exp_q.push_back({REQ1, 8'h00, 1'b1});
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_resp(ok, r, n);
        e = exp_q.pop_front();
        checks++;
        if (!ok || r !== e) begin
            errors++; $display("FAIL carry_resp got ok%b %h exp %h", ok, r, e);
        end
    endtask

    task automatic test_contention;
        int    grants = 0;
        int    resps  = 0;
        int    k[2]   = '{0, 0};
        bit    pend   = 1'b0;
        int    pend_id = 0;
        int    g;
        resp_t r, e;
        req0_a = op_a(0, 0); req0_b = op_b(0); req0_sel = 4'h0;
        req1_a = op_a(1, 0); req1_b = op_b(1); req1_sel = 4'h0;
        req_valid = 2'b11;
        for (int cyc = 0; cyc < 60 && (grants < 4 || resps < 4); cyc++) begin
            @(negedge clk);
            if (pend) begin
                if (k[pend_id] < 2) begin
                    if (pend_id == 0) begin
                        req0_a = op_a(0, k[0]); req0_sel = 4'(k[0]);
                    end else begin
                        req1_a = op_a(1, k[1]); req1_sel = 4'(k[1]);
                    end
                end else begin
                    req_valid[pend_id] = 1'b0;
                end
                pend = 1'b0;
            end
            #1;
            checks++;
            if (req_ready === 2'b11) begin
                errors++; $display("FAIL cont_onehot got %b exp at most one bit", req_ready);
            end
            if (req_ready != 2'b00) begin
                g = req_ready[1] ? 1 : 0;
                checks++;
                if (g != grants % 2) begin
                    errors++; $display("FAIL cont_order grant %0d got %0d exp %0d", grants, g, grants % 2);
                end
                if (g == 0) exp_q.push_back(make_exp(REQ0, req0_a, req0_b, req0_sel));
                else        exp_q.push_back(make_exp(REQ1, req1_a, req1_b, req1_sel));
                k[g]++;
                grants++;
                pend    = 1'b1;
                pend_id = g;
            end
            if (resp_valid) begin
                r = {resp_id, resp_data, resp_carry};
                e = exp_q.pop_front();
                resps++;
                checks++;
                if (r !== e) begin
                    errors++; $display("FAIL cont_resp %0d got %h exp %h", resps, r, e);
                end
            end
        end
        checks++;
        if (grants != 4 || resps != 4) begin
            errors++; $display("FAIL cont_count got %0d/%0d exp 4/4", grants, resps);
        end
    endtask

    task automatic test_backpressure;
        bit    ok;
        int    n;
        resp_t r, e, hold;
        @(negedge clk);
        resp_ready = 1'b0;
        req0_a = 8'h5A; req0_b = 8'h3C; req0_sel = 4'h1;
        req_valid = 2'b01;
        #1;
        exp_q.push_back(make_exp(REQ0, req0_a, req0_b, req0_sel));
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_resp(ok, hold, n);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_valid got timeout exp resp_valid");
        end
        req1_a = 8'h33; req1_b = 8'h11; req1_sel = 4'h0;
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({resp_valid, resp_id, resp_data, resp_carry, req_ready} !== {1'b1, hold, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got v%b %h rdy %b exp v1 %h rdy 00",
                         i, resp_valid, {resp_id, resp_data, resp_carry}, req_ready, hold);
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (hold !== e) begin
            errors++; $display("FAIL bp_resp got %h exp %h", hold, e);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got %b exp 0", resp_valid);
        end
        wait_ready(1, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_next got no grant exp req_ready[1]");
        end
        exp_q.push_back(make_exp(REQ1, req1_a, req1_b, req1_sel));
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_resp(ok, r, n);
        e = exp_q.pop_front();
        checks++;
        if (!ok || r !== e) begin
            errors++; $display("FAIL bp_next_resp got ok%b %h exp %h", ok, r, e);
        end
    endtask

    task automatic test_sel_sweep;
        bit    ok;
        int    n;
        resp_t r, e;
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            req0_a = 8'h0A; req0_b = 8'h02; req0_sel = 4'(s);
            req_valid = 2'b01;
            #1;
            wait_ready(0, ok);
            exp_q.push_back(make_exp(REQ0, 8'h0A, 8'h02, 4'(s)));
            @(posedge clk); #1;
            req_valid = 2'b00;
            checks++;
            if (!ok || alu_sel !== 4'(s) || alu_a !== 8'h0A || alu_b !== 8'h02) begin
                errors++;
                $display("FAIL sweep_sel got ok%b %h/%h/%h exp 0a/02/%h", ok, alu_a, alu_b, alu_sel, 4'(s));
            end
            wait_resp(ok, r, n);
            e = exp_q.pop_front();
            checks++;
            if (!ok || r !== e) begin
                errors++; $display("FAIL sweep_resp sel %0d got ok%b %h exp %h", s, ok, r, e);
            end
        end
    endtask

    task automatic test_reset_mid_op;
        bit    ok;
        bit    seen = 1'b0;
        int    n;
        resp_t r, e;
        @(negedge clk);
        req1_a = 8'h77; req1_b = 8'h99; req1_sel = 4'h0;
        req_valid = 2'b10;
        #1;
        wait_ready(1, ok);
        exp_q.push_back(make_exp(REQ1, req1_a, req1_b, req1_sel));
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        checks++;
        if ({req_ready, alu_a, alu_b, alu_sel, resp_valid, resp_id, resp_data, resp_carry} !== 33'h0) begin
            errors++;
            $display("FAIL midrst_state got rdy%b %h/%h/%h v%b id%b d%h c%b exp all 0",
                     req_ready, alu_a, alu_b, alu_sel, resp_valid, resp_id, resp_data, resp_carry);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL midrst_noresp got resp_valid 1 exp 0");
        end
        @(negedge clk);
        req0_a = 8'h21; req0_b = 8'h43; req0_sel = 4'h0;
        req_valid = 2'b01;
        #1;
        wait_ready(0, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL midrst_grant got no grant exp req_ready[0]");
        end
        exp_q.push_back({REQ0, 8'h64, 1'b0});
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_resp(ok, r, n);
        e = exp_q.pop_front();
        checks++;
        if (!ok || r !== e) begin
            errors++; $display("FAIL midrst_resp got ok%b %h exp %h", ok, r, e);
        end
    endtask

    initial begin
        rst        = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 2'b00;
        req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_a = '0; req1_b = '0; req1_sel = '0;
        test_reset;
        test_single;
        test_carry;
        test_contention;
        test_backpressure;
        test_sel_sweep;
        test_reset_mid_op;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no finish exp finish before 100us");
        $fatal(1, "watchdog expired");
    end

endmodule
